// File: rtl/encoder_pkg.sv
// Shared types and constants for the token_encoder block.
package encoder_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCheck,
      StFetch,
      StCompare,
      StSkip,
      StEmit,
      StDone
   } enc_state_t;

   localparam int unsigned NullCharDefault = 0;

   // UNK is the all-ones ID of the given width.
   function automatic int unsigned unk_id(input int unsigned id_width);
      return (32'd1 << id_width) - 32'd1;
   endfunction

endpackage

// File: rtl/sp_ram.sv
// Simple RAM: one write port, one synchronous read port with 1-cycle latency.
module sp_ram #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] waddr_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0] raddr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage write and registered read; contents are deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
      rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/token_encoder.sv
// Greedy longest-match tokenizer over a NULL-terminated vocabulary RAM and input RAM.
// Optional build macro: ENCODER_STATS_EN adds saturating tok_count/unk_count outputs.
module token_encoder
   import encoder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ID_WIDTH   = 8,
   parameter int unsigned NULL_CHAR  = NullCharDefault
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cs,
   input  logic                  vocab_we,
   input  logic [ADDR_WIDTH-1:0] vocab_waddr,
   input  logic [DATA_WIDTH-1:0] vocab_wdata,
   input  logic                  in_we,
   input  logic [ADDR_WIDTH-1:0] in_waddr,
   input  logic [DATA_WIDTH-1:0] in_wdata,
   output logic                  tok_valid,
   input  logic                  tok_ready,
   output logic [ID_WIDTH-1:0]   tok_id,
   output logic [ADDR_WIDTH:0]   tok_len,
   output logic                  busy,
   output logic                  done,
`ifdef ENCODER_STATS_EN
   output logic [15:0]           tok_count,
   output logic [15:0]           unk_count,
`endif
   output logic                  vocab_overflow
);

   localparam logic [ID_WIDTH-1:0]   Unk     = ID_WIDTH'(unk_id(ID_WIDTH));
   localparam logic [DATA_WIDTH-1:0] NullC   = DATA_WIDTH'(NULL_CHAR);
   localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;

   enc_state_t                state_q, state_d;
   logic                      phase_q, phase_d;     // second cycle of a 2-cycle read wait
   logic [ADDR_WIDTH-1:0]     base_q, base_d;
   logic [ADDR_WIDTH-1:0]     av_q, av_d;
   logic [ADDR_WIDTH-1:0]     ai_q, ai_d;
   logic [ADDR_WIDTH:0]       len_q, len_d;
   logic [ID_WIDTH-1:0]       eid_q, eid_d;
   logic [ID_WIDTH-1:0]       best_id_q, best_id_d;
   logic [ADDR_WIDTH:0]       best_len_q, best_len_d;
   logic                      ovf_q, ovf_d;
   logic                      adv_entry;
   logic [ADDR_WIDTH-1:0]     in_raddr;
   logic [DATA_WIDTH-1:0]     vocab_rdata, in_rdata;
   logic [ID_WIDTH-1:0]       emit_id;
   logic [ADDR_WIDTH:0]       emit_len;
   logic [ADDR_WIDTH+1:0]     adv_sum;

   // CHECK looks at the token start; every other state walks the input via ai.
   assign in_raddr = (state_q == StCheck) ? base_q : ai_q;

   sp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) vocab_ram (
      .clk_i   (clk),
      .we_i    (vocab_we & ~busy),
      .waddr_i (vocab_waddr),
      .wdata_i (vocab_wdata),
      .raddr_i (av_q),
      .rdata_o (vocab_rdata)
   );

   sp_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) input_ram (
      .clk_i   (clk),
      .we_i    (in_we & ~busy),
      .waddr_i (in_waddr),
      .wdata_i (in_wdata),
      .raddr_i (in_raddr),
      .rdata_o (in_rdata)
   );

   // Token value presented in EMIT; no match at all yields a 1-character UNK.
   always_comb begin
      emit_id  = (best_len_q == '0) ? Unk : best_id_q;
      emit_len = (best_len_q == '0) ? (ADDR_WIDTH+1)'(1) : best_len_q;
      adv_sum  = (ADDR_WIDTH+2)'(base_q) + (ADDR_WIDTH+2)'(emit_len);
   end

   // Next-state logic for the matching walk.
   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      base_d     = base_q;
      av_d       = av_q;
      ai_d       = ai_q;
      len_d      = len_q;
      eid_d      = eid_q;
      best_id_d  = best_id_q;
      best_len_d = best_len_q;
      ovf_d      = ovf_q;
      adv_entry  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cs) begin
               state_d = StCheck;
               phase_d = 1'b0;
               base_d  = '0;
               ovf_d   = 1'b0;
            end
         end
         StCheck: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (in_rdata == NullC) begin
                  state_d = StDone;
               end else begin
                  state_d    = StFetch;
                  av_d       = '0;
                  ai_d       = base_q;
                  len_d      = '0;
                  eid_d      = '0;
                  best_id_d  = '0;
                  best_len_d = '0;
               end
            end
         end
         StFetch: state_d = StCompare;
         StCompare: begin
            if (vocab_rdata == NullC) begin
               if (len_q == '0) begin
                  state_d = StEmit;
               end else begin
                  // Strictly longer wins, so ties keep the lower ID.
                  if (len_q > best_len_q) begin
                     best_id_d  = eid_q;
                     best_len_d = len_q;
                  end
                  adv_entry = 1'b1;
               end
            end else if (vocab_rdata == in_rdata && ai_q != AddrMax) begin
               if (av_q == AddrMax) begin
                  ovf_d   = 1'b1;
                  state_d = StEmit;
               end else begin
                  av_d    = av_q + 1'b1;
                  ai_d    = ai_q + 1'b1;
                  len_d   = len_q + 1'b1;
                  state_d = StFetch;
               end
            end else begin
               // Mismatch: the current vocab char is non-NULL, so step past it first.
               if (av_q == AddrMax) begin
                  ovf_d   = 1'b1;
                  state_d = StEmit;
               end else begin
                  av_d    = av_q + 1'b1;
                  phase_d = 1'b0;
                  state_d = StSkip;
               end
            end
         end
         StSkip: begin
            if (!phase_q) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (vocab_rdata == NullC) begin
                  adv_entry = 1'b1;
               end else if (av_q == AddrMax) begin
                  ovf_d   = 1'b1;
                  state_d = StEmit;
               end else begin
                  av_d = av_q + 1'b1;
               end
            end
         end
         StEmit: begin
            if (tok_ready) begin
               if (adv_sum[ADDR_WIDTH+1:ADDR_WIDTH] != 2'b00) begin
                  state_d = StDone;
               end else begin
                  base_d  = adv_sum[ADDR_WIDTH-1:0];
                  phase_d = 1'b0;
                  state_d = StCheck;
               end
            end
         end
         StDone: state_d = StDone;
         default: state_d = StIdle;
      endcase
      // Move to the next vocab entry, ending the scan on av wrap or ID exhaustion.
      if (adv_entry) begin
         if (av_q == AddrMax) begin
            ovf_d   = 1'b1;
            state_d = StEmit;
         end else if ((eid_q + 1'b1) == Unk) begin
            av_d    = av_q + 1'b1;
            state_d = StEmit;
         end else begin
            av_d    = av_q + 1'b1;
            eid_d   = eid_q + 1'b1;
            len_d   = '0;
            ai_d    = base_q;
            state_d = StFetch;
         end
      end
      if (state_q != StIdle && !cs) begin
         state_d = StIdle;
      end
   end

   // State and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         phase_q    <= 1'b0;
         base_q     <= '0;
         av_q       <= '0;
         ai_q       <= '0;
         len_q      <= '0;
         eid_q      <= '0;
         best_id_q  <= '0;
         best_len_q <= '0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         base_q     <= base_d;
         av_q       <= av_d;
         ai_q       <= ai_d;
         len_q      <= len_d;
         eid_q      <= eid_d;
         best_id_q  <= best_id_d;
         best_len_q <= best_len_d;
         ovf_q      <= ovf_d;
      end
   end

   // Outputs decoded from state; token fields are zero outside EMIT.
   always_comb begin
      tok_valid      = (state_q == StEmit);
      tok_id         = tok_valid ? emit_id : '0;
      tok_len        = tok_valid ? emit_len : '0;
      busy           = (state_q != StIdle) && (state_q != StDone);
      done           = (state_q == StDone);
      vocab_overflow = ovf_q;
   end

`ifdef ENCODER_STATS_EN
   logic [15:0] tok_cnt_q, unk_cnt_q;

   // Saturating token/UNK counters, cleared when a new run starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tok_cnt_q <= '0;
         unk_cnt_q <= '0;
      end else if (state_q == StIdle && cs) begin
         tok_cnt_q <= '0;
         unk_cnt_q <= '0;
      end else if (tok_valid && tok_ready) begin
         if (tok_cnt_q != 16'hFFFF) tok_cnt_q <= tok_cnt_q + 16'd1;
         if (emit_id == Unk && unk_cnt_q != 16'hFFFF) unk_cnt_q <= unk_cnt_q + 16'd1;
      end
   end

   assign tok_count = tok_cnt_q;
   assign unk_count = unk_cnt_q;
`endif

endmodule

// File: tb/tb_token_encoder.sv
// Self-checking bench for token_encoder: directed cases plus randomized vocab/input runs.
module tb_token_encoder;
   import encoder_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n, cs, vocab_we, in_we, tok_ready;
   logic [3:0] vocab_waddr, in_waddr;
   logic [7:0] vocab_wdata, in_wdata;
   logic       tok_valid, busy, done, vocab_overflow;
   logic [7:0] tok_id;
   logic [4:0] tok_len;
`ifdef ENCODER_STATS_EN
   logic [15:0] tok_count, unk_count;
`endif

   int n_checks = 0;
   int n_bad    = 0;

   logic [7:0] vmem [16];
   logic [7:0] imem [16];
   int         exp_id[$];
   int         exp_len[$];
   bit         exp_ovf;
   int         n_tok;
   int         lat;

   token_encoder dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cs             (cs),
      .vocab_we       (vocab_we),
      .vocab_waddr    (vocab_waddr),
      .vocab_wdata    (vocab_wdata),
      .in_we          (in_we),
      .in_waddr       (in_waddr),
      .in_wdata       (in_wdata),
      .tok_valid      (tok_valid),
      .tok_ready      (tok_ready),
      .tok_id         (tok_id),
      .tok_len        (tok_len),
      .busy           (busy),
      .done           (done),
`ifdef ENCODER_STATS_EN
      .tok_count      (tok_count),
      .unk_count      (unk_count),
`endif
      .vocab_overflow (vocab_overflow)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // '.' stands for the NULL character in these helper strings.
   task automatic set_vocab(input string s);
      for (int a = 0; a < 16; a++) vmem[a] = 8'h00;
      for (int a = 0; a < s.len() && a < 16; a++) vmem[a] = (s[a] == ".") ? 8'h00 : s[a];
   endtask

   task automatic set_input(input string s);
      for (int a = 0; a < 16; a++) imem[a] = 8'h00;
      for (int a = 0; a < s.len() && a < 16; a++) imem[a] = (s[a] == ".") ? 8'h00 : s[a];
   endtask

   task automatic load_rams();
      for (int a = 0; a < 16; a++) begin
         @(negedge clk);
         vocab_we = 1'b1; vocab_waddr = 4'(a); vocab_wdata = vmem[a];
         in_we    = 1'b1; in_waddr    = 4'(a); in_wdata    = imem[a];
      end
      @(negedge clk);
      vocab_we = 1'b0;
      in_we    = 1'b0;
   endtask

   // Reference: list complete vocab entries, then greedy longest match at each position.
   task automatic model_run();
      int  starts[$];
      int  lens[$];
      int  a, s, p, bl, bid;
      bit  term, ok;
      exp_id.delete();
      exp_len.delete();
      term = 1'b0;
      a = 0;
      while (a < 16) begin
         if (vmem[a] == 8'h00) begin
            term = 1'b1;
            break;
         end
         s = a;
         while (a < 16 && vmem[a] != 8'h00) a++;
         if (a >= 16) break;
         starts.push_back(s);
         lens.push_back(a - s);
         a++;
      end
      p = 0;
      while (p < 16 && imem[p] != 8'h00) begin
         bl  = 0;
         bid = 255;
         for (int e = 0; e < starts.size(); e++) begin
            if (lens[e] > bl) begin
               ok = 1'b1;
               for (int k = 0; k < lens[e]; k++)
                  if (p + k > 15 || imem[p + k] != vmem[starts[e] + k]) ok = 1'b0;
               if (ok) begin
                  bl  = lens[e];
                  bid = e;
               end
            end
         end
         if (bl == 0) bl = 1;
         exp_id.push_back(bid);
         exp_len.push_back(bl);
         p += bl;
      end
      exp_ovf = !term && (exp_id.size() > 0);
   endtask

   // Start a run, consume tokens (optionally stalling each one), compare with exp_* queues.
   task automatic run_encoder(input string tag, input int stall, input int budget);
      int         st, nunk;
      bit         got_done;
      logic [7:0] hid;
      logic [4:0] hlen;
      n_tok = 0; st = 0; got_done = 1'b0; lat = budget; hid = '0; hlen = '0;
      @(negedge clk);
      cs = 1'b1;
      tok_ready = 1'b1;
      for (int cyc = 0; cyc < budget && !got_done; cyc++) begin
         @(negedge clk);
         if (done) begin
            got_done = 1'b1;
            lat = cyc + 1;
         end else if (tok_valid) begin
            if (st == 0) begin
               hid = tok_id; hlen = tok_len;
            end else begin
               check_eq({tag, "_hold_id"}, tok_id, hid);
               check_eq({tag, "_hold_len"}, tok_len, hlen);
            end
            if (st < stall) begin
               tok_ready = 1'b0;
               st++;
            end else begin
               tok_ready = 1'b1;
               st = 0;
               if (n_tok < exp_id.size()) begin
                  check_eq($sformatf("%s_id%0d", tag, n_tok), tok_id, exp_id[n_tok]);
                  check_eq($sformatf("%s_len%0d", tag, n_tok), tok_len, exp_len[n_tok]);
               end else begin
                  check_eq({tag, "_extra_tok"}, n_tok, exp_id.size());
               end
               n_tok++;
            end
         end else begin
            tok_ready = 1'b1;
         end
      end
      check_eq({tag, "_done"}, got_done, 1);
      check_eq({tag, "_ntok"}, n_tok, exp_id.size());
      check_eq({tag, "_ovf"}, vocab_overflow, exp_ovf);
`ifdef ENCODER_STATS_EN
      nunk = 0;
      foreach (exp_id[i]) if (exp_id[i] == 255) nunk++;
      check_eq({tag, "_tok_count"}, tok_count, exp_id.size());
      check_eq({tag, "_unk_count"}, unk_count, nunk);
`else
      nunk = 0;
`endif
      @(negedge clk);
      cs = 1'b0;
      @(negedge clk);
      check_eq({tag, "_done_clr"}, done, 0);
   endtask

   task automatic set_exp(input int id0, input int l0, input int id1, input int l1,
                          input int id2, input int l2, input int n, input bit ovf);
      exp_id.delete();
      exp_len.delete();
      if (n > 0) begin exp_id.push_back(id0); exp_len.push_back(l0); end
      if (n > 1) begin exp_id.push_back(id1); exp_len.push_back(l1); end
      if (n > 2) begin exp_id.push_back(id2); exp_len.push_back(l2); end
      exp_ovf = ovf;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      int ne, nl, a;
      rst_n = 1'b0; cs = 1'b0; tok_ready = 1'b0;
      vocab_we = 1'b0; vocab_waddr = '0; vocab_wdata = '0;
      in_we = 1'b0; in_waddr = '0; in_wdata = '0;
      #23;
      check_eq("rst_valid", tok_valid, 0);
      check_eq("rst_id", tok_id, 0);
      check_eq("rst_len", tok_len, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_ovf", vocab_overflow, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic: vocab {a, ab, b}, input "abba".
      set_vocab("a.ab.b..");
      set_input("abba.");
      load_rams();
      check_eq("ram_vocab3", dut.vocab_ram.mem_q[3], 8'h62);
      check_eq("ram_input2", dut.input_ram.mem_q[2], 8'h62);
      set_exp(1, 2, 2, 1, 0, 1, 3, 1'b0);
      run_encoder("abba", 0, 2000);

      // Unmatched character becomes UNK.
      set_input("ac.");
      load_rams();
      set_exp(0, 1, 255, 1, 0, 0, 2, 1'b0);
      run_encoder("ac", 0, 2000);

      // Backpressure: each token held for 5 cycles.
      set_input("abba.");
      load_rams();
      set_exp(1, 2, 2, 1, 0, 1, 3, 1'b0);
      run_encoder("stall", 5, 3000);

      // Empty input finishes quickly without any token.
      set_input(".");
      load_rams();
      set_exp(0, 0, 0, 0, 0, 0, 0, 1'b0);
      run_encoder("empty", 0, 50);
      check_eq("empty_latency_le3", (lat <= 3), 1);

      // Vocab without any terminator.
      for (int i = 0; i < 16; i++) vmem[i] = 8'h78;
      set_input("x.");
      load_rams();
      set_exp(255, 1, 0, 0, 0, 0, 1, 1'b1);
      run_encoder("ovf", 0, 2000);

      // Async reset while skipping an entry, then a clean rerun.
      set_vocab("a.ab.b..");
      set_input("abba.");
      load_rams();
      @(negedge clk);
      cs = 1'b1; tok_ready = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (dut.state_q == StSkip) found = 1'b1;
      end
      check_eq("reach_skip", found, 1);
      rst_n = 1'b0;
      #1;
      check_eq("rst_mid_valid", tok_valid, 0);
      check_eq("rst_mid_busy", busy, 0);
      cs = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      set_exp(1, 2, 2, 1, 0, 1, 3, 1'b0);
      run_encoder("rerun_rst", 0, 2000);

      // Drop cs with a token pending; a write attempted while busy must be ignored.
      @(negedge clk);
      cs = 1'b1; tok_ready = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (tok_valid) found = 1'b1;
      end
      check_eq("reach_valid", found, 1);
      vocab_we = 1'b1; vocab_waddr = 4'd0; vocab_wdata = 8'h7a;
      @(negedge clk);
      vocab_we = 1'b0;
      cs = 1'b0;
      @(negedge clk);
      check_eq("abort_valid", tok_valid, 0);
      check_eq("abort_busy", busy, 0);
      check_eq("busy_write_ignored", dut.vocab_ram.mem_q[0], 8'h61);
      run_encoder("rerun_cs", 0, 2000);

      // Randomized vocab and input against the reference model.
      for (int t = 0; t < 10; t++) begin
         for (int i = 0; i < 16; i++) vmem[i] = 8'h00;
         a  = 0;
         ne = $urandom_range(1, 3);
         for (int e = 0; e < ne; e++) begin
            nl = $urandom_range(1, 3);
            for (int k = 0; k < nl; k++) begin
               vmem[a] = 8'h61 + 8'($urandom_range(0, 2));
               a++;
            end
            a++;
         end
         for (int i = 0; i < 16; i++) imem[i] = 8'h00;
         nl = $urandom_range(0, 10);
         for (int i = 0; i < nl; i++) imem[i] = 8'h61 + 8'($urandom_range(0, 3));
         load_rams();
         model_run();
         run_encoder($sformatf("rand%0d", t), $urandom_range(0, 2), 3000);
      end

      $display("test done: total=%0d bad=%0d", n_checks, n_bad);
      $finish;
   end

endmodule

// File: doc/token_encoder.md
Name: token_encoder

Overview:
- Parametrised greedy longest-match tokenizer; successor of the single-match vocab/input matcher.
- Holds a vocabulary RAM of NULL-terminated entries and an input RAM holding a NULL-terminated string.
- On `cs`, walks the input and emits one token ID per longest vocabulary match on a valid/ready stream. Unmatched characters emit UNK.
- Sits between the host loader and the embedding lookup in the tensor_core front end.

Parameters:
- ADDR_WIDTH, 4, address width of both RAMs (depth 2**ADDR_WIDTH each)
- DATA_WIDTH, 8, character width
- ID_WIDTH, 8, token ID width; UNK = all ones; valid IDs 0..2**ID_WIDTH-2
- NULL_CHAR, 0, terminator character value

Ports:
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `cs` in 1: start/enable, level
- `vocab_we` in 1: vocabulary RAM write enable
- `vocab_waddr` in ADDR_WIDTH: vocabulary write address
- `vocab_wdata` in DATA_WIDTH: vocabulary write data
- `in_we` in 1: input RAM write enable
- `in_waddr` in ADDR_WIDTH: input write address
- `in_wdata` in DATA_WIDTH: input write data
- `tok_valid` out 1: token available
- `tok_ready` in 1: consumer accepts token
- `tok_id` out ID_WIDTH: token ID (vocab entry index or UNK)
- `tok_len` out ADDR_WIDTH+1: characters consumed by this token
- `busy` out 1: FSM not in IDLE/DONE
- `done` out 1: input fully tokenized
- `vocab_overflow` out 1: sticky, vocab scan wrapped without an empty-entry terminator

Behaviour:
- Reset: all outputs 0, FSM IDLE, all pointers 0. RAM contents are not reset.
- RAMs: synchronous read, 1-cycle latency. Writes are ignored while `busy`.
- Vocabulary layout: entries are back-to-back, each NULL-terminated. The entry index is the ID. An empty entry (NULL at an entry start) ends the vocabulary.
- FSM states: IDLE, CHECK, FETCH, COMPARE, SKIP, EMIT, DONE.
- IDLE:
  - `cs`=1 -> CHECK with base=0, vocab_overflow cleared.
- CHECK:
  - Read input[base].
  - NULL -> DONE.
  - Otherwise -> FETCH with av=0, ai=base, len=0, entry_id=0, best_len=0.
- FETCH: issue reads of vocab[av] and input[ai]; next cycle COMPARE.
- COMPARE:
  - vocab NULL and len=0 -> end of vocab -> EMIT.
  - vocab NULL and len>0 -> full entry match. If len > best_len (strict; ties keep the lower ID), record best_id=entry_id and best_len=len. Then entry_id++, av++, len=0, ai=base -> FETCH.
  - vocab == input and non-NULL -> av++, ai++, len++ -> FETCH.
  - Mismatch (including input NULL) -> SKIP.
- SKIP:
  - Advance av one per 2 cycles until vocab NULL.
  - Then av++, entry_id++, len=0, ai=base -> FETCH.
- EMIT:
  - tok_valid=1.
  - tok_id = best_id, or UNK if best_len=0.
  - tok_len = best_len, or 1 if best_len=0.
  - tok_id and tok_len are stable while tok_valid && !tok_ready.
  - On handshake: base += tok_len -> CHECK. tok_valid drops the cycle after the handshake.
- DONE:
  - done=1, busy=0, held while `cs`=1.
  - `cs`=0 -> IDLE, done=0.
- Boundary conditions:
  - av wrapping from 2**ADDR_WIDTH-1 to 0 -> vocab_overflow=1, treated as end of vocab -> EMIT.
  - ai wrapping -> treated as mismatch.
  - base wrapping on advance -> DONE.
  - entry_id reaching UNK -> treated as end of vocab.
  - `cs`=0 in any non-IDLE state -> IDLE next cycle. tok_valid drops, and a pending token is discarded.
  - Async reset mid-operation returns to the reset state immediately. No token is emitted.

Optional Feature:
- Macro: ENCODER_STATS_EN
- Defined:
  - Adds outputs `tok_count` (16 bits) and `unk_count` (16 bits).
  - Each increments on every tok handshake (unk_count only for UNK tokens) and saturates at 0xFFFF.
  - Both clear on the IDLE->CHECK transition and on reset.
- Undefined: the ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package encoder_pkg holds:
  - the state enum `enc_state_t`
  - the UNK-ID derivation function of ID_WIDTH
  - the NULL_CHAR default constant
- Sub-module `sp_ram`: one write port and one synchronous read port, parametrised ADDR_WIDTH/DATA_WIDTH.
  - Instantiated as `vocab_ram` and `input_ram`, hierarchy-visible for bench monitoring.

Test Plan:
- Vocab "a\0ab\0b\0\0", input "abba\0", tok_ready=1 -> tokens (id1,len2), (id2,len1), (id0,len1); then done=1, vocab_overflow=0.
- Same vocab, input "ac\0" -> (id0,len1), (id255,len1); then done=1. With ENCODER_STATS_EN: tok_count=2, unk_count=1.
- Input "abba\0", tok_ready held low 5 cycles on each token -> tok_valid stays high, tok_id/tok_len unchanged; exactly 3 handshakes.
- Input "\0" -> done=1 within 3 cycles of cs=1; tok_valid never asserted.
- Vocab RAM filled with 'x' (no NULL), input "x\0" -> vocab_overflow=1, token (id255,len1), done=1.
- rst_n pulsed low during SKIP, and separately cs dropped while tok_valid=1 -> next cycle tok_valid=0, busy=0. A rerun with cs=1 produces the full correct sequence from base 0.
